pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch: one outstanding request to instruction memory at a time, with a valid/ready handshake.
- Picks the next-PC source each fetch: sequential PC+4, branch target PC+imm, JALR ALU result, or the LSB-masked JALR result.
- Sits between the execute-stage redirect logic and the IF/ID register. Handles decode stalls, redirects and discarding of stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request
- imem_addr  out  ADDR_W  fetch address; stable while imem_req_valid=1 and imem_req_ready=0
- imem_rsp_valid  in  1  one-cycle response strobe; exactly one per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  in  32  fetched instruction
- if_valid  out  1  instruction valid to decode
- if_instr  out  32  instruction to decode
- if_pc  out  ADDR_W  PC of if_instr
- id_ready  in  1  decode accepts; 0 = stall
- redirect_valid  in  1  one-cycle control-transfer strobe from execute
- redirect_sel  in  2  01 PC+imm, 10 ALU, 11 AND-masked; 00 = ignored
- pc_plus_imm  in  ADDR_W  branch/JAL target
- alu_target  in  ADDR_W  JALR target
- and_target  in  ADDR_W  JALR target with bit0 cleared
- pc_sel  out  2  source used for the most recent PC update (00 +4, 01 imm, 10 ALU, 11 AND)

Behaviour:
Reset values (asynchronous, active-high rst, clock clk):
- pc = RESET_PC
- imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, pc_sel=00
- state=BOOT, stale=0

States:
- BOOT: one cycle, no outputs asserted. Next state REQ.
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready: latch req_pc=pc, go to WAIT.
- WAIT: wait for imem_rsp_valid.
  - If stale=1: discard the response, clear stale, go to REQ.
  - Otherwise: if_valid=1, if_instr=imem_rsp_data, if_pc=req_pc, pc=req_pc+4, pc_sel=00, go to HOLD.
- HOLD: if_valid stays 1 and the instruction/PC are held until id_ready=1.
  - On id_ready=1: drop if_valid next cycle, go to REQ.
  - Fetch latency is therefore at least 3 cycles per instruction. No prefetch.

Redirect (redirect_valid=1, redirect_sel≠00), in any state except BOOT:
- pc = selected target; pc_sel = redirect_sel. Takes effect next cycle.
- if_valid cleared next cycle (flush), including in HOLD.
- In REQ, request not yet accepted: imem_addr switches to the new pc next cycle. An abandoned unaccepted request is legal.
- In REQ, imem_req_ready=1 in the same cycle: the accepted request is for the old pc. Set stale=1 and go to WAIT.
- In WAIT: set stale=1; the pending response is discarded.
- In WAIT with imem_rsp_valid in the same cycle: the response is discarded and if_valid is not raised. Go to REQ with the new pc.
- In HOLD: go to REQ.

Priority and boundary conditions:
- Redirect beats the id_ready stall.
- redirect_sel=00 with redirect_valid=1: no effect.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFF_FFFC+4 = 0.
- rst asserted mid-operation returns immediately to the reset values. Any response arriving afterwards is ignored, because BOOT/REQ do not sample imem_rsp_valid.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Extra output misalign_trap (1 bit, reset 0).
  - A redirect whose target has bits[1:0]≠00 does not update pc, which keeps the sequential value.
  - Pulses misalign_trap for one cycle and performs the flush.
  - pc_sel=00 on that cycle.
- Undefined:
  - The port is absent.
  - Targets are loaded unchanged, misaligned or not.

Test Plan:
- Reset, imem ready always, 1-cycle response, id_ready=1 → imem_addr sequence 0x0, 0x4, 0x8. if_pc matches each address, with if_valid one cycle per instruction.
- id_ready=0 for 5 cycles while if_instr=0x00500093 → if_valid, if_instr and if_pc held. No new imem_req_valid until id_ready returns 1.
- imem_req_ready=0 for 4 cycles at addr 0x8 → imem_addr held at 0x8 with imem_req_valid=1. Accepted on the 5th cycle.
- Redirect sel=01, pc_plus_imm=0x100, during WAIT for 0xC → response for 0xC dropped (if_valid stays 0). Next request at 0x100, pc_sel=01.
- Redirect sel=11, and_target=0x200, in HOLD with id_ready=0 → if_valid drops next cycle. Next fetch at 0x200, followed by 0x204.
- With PC_MISALIGN_TRAP_EN: redirect sel=10, alu_target=0x102 → misaligned target rejected: misalign_trap pulses once and no fetch is issued to 0x102.
- Without PC_MISALIGN_TRAP_EN: same redirect → next fetch is issued at 0x102.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and issues one instruction fetch at a time to imem.
// Optional PC_MISALIGN_TRAP_EN rejects misaligned redirect targets and pulses misalign_trap.
module pc_fetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_sel,
  input  logic [ADDR_W-1:0] pc_plus_imm,
  input  logic [ADDR_W-1:0] alu_target,
  input  logic [ADDR_W-1:0] and_target,
  output logic [1:0]        pc_sel
`ifdef PC_MISALIGN_TRAP_EN
  , output logic            misalign_trap
`endif
);
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d, if_pc_q, if_pc_d, tgt;
  logic [31:0]       if_instr_q, if_instr_d;
  logic [1:0]        pc_sel_q, pc_sel_d;
  logic              stale_q, stale_d, if_valid_q, if_valid_d, trap_q, trap_d;
  logic              redir, misaligned;
  always_comb begin
    redir = redirect_valid && redirect_sel != 2'b00 && state_q != S_BOOT;
    tgt = redirect_sel == 2'b01 ? pc_plus_imm : redirect_sel == 2'b10 ? alu_target : and_target;
`ifdef PC_MISALIGN_TRAP_EN
    misaligned = redir && tgt[1:0] != 2'b00;
`else
    misaligned = 1'b0;
`endif
    state_d = state_q;
    pc_d = pc_q;
    pc_sel_d = pc_sel_q;
    req_pc_d = req_pc_q;
    stale_d = stale_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d = if_pc_q;
    trap_d = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: if (imem_req_ready) begin
        // A redirect in the accept cycle leaves an in-flight fetch for the old pc
        req_pc_d = pc_q;
        stale_d = redir;
        state_d = S_WAIT;
      end
      S_WAIT: if (imem_rsp_valid) begin
        stale_d = 1'b0;
        if (stale_q || redir) state_d = S_REQ;
        else begin
          if_valid_d = 1'b1;
          if_instr_d = imem_rsp_data;
          if_pc_d = req_pc_q;
          pc_d = req_pc_q + ADDR_W'(4);
          pc_sel_d = 2'b00;
          state_d = S_HOLD;
        end
      end else if (redir) stale_d = 1'b1;
      S_HOLD: if (id_ready || redir) begin
        if_valid_d = 1'b0;
        state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase
    if (redir) begin
      if_valid_d = 1'b0;
      pc_d = misaligned ? pc_q : tgt;
      pc_sel_d = misaligned ? 2'b00 : redirect_sel;
      trap_d = misaligned;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q <= RESET_PC;
      req_pc_q <= RESET_PC;
      pc_sel_q <= 2'b00;
      stale_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q <= '0;
      trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      pc_sel_q <= pc_sel_d;
      stale_q <= stale_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q <= if_pc_d;
      trap_q <= trap_d;
    end
  end
  assign imem_req_valid = state_q == S_REQ;
  assign imem_addr = pc_q;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc = if_pc_q;
  assign pc_sel = pc_sel_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q;
`endif
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed per-cycle vector table plus a mid-operation reset sequence.
module tb_pc_fetch_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, if_valid, id_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rsp_data, if_instr, if_pc, pc_plus_imm, alu_target, and_target;
  logic [1:0] redirect_sel, pc_sel;
  logic trap;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .pc_plus_imm(pc_plus_imm), .alu_target(alu_target), .and_target(and_target),
    .pc_sel(pc_sel)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign_trap(trap)
`endif
  );
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MA = 32'h604;
  localparam logic TR = 1'b1;
  localparam logic [1:0] MS = 2'b00;
`else
  assign trap = 1'b0;
  localparam logic [31:0] MA = 32'h102;
  localparam logic TR = 1'b0;
  localparam logic [1:0] MS = 2'b10;
`endif
  typedef struct {
    logic rdy, rv; logic [31:0] rdata; logic idr, redv; logic [1:0] sel; logic [31:0] tgt;
    logic reqv; logic [31:0] addr; logic ifv; logic [31:0] instr, ifpc; logic [1:0] psel; logic tr;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rdata, logic idr, logic redv,
      logic [1:0] sel, logic [31:0] tgt, logic reqv, logic [31:0] addr, logic ifv,
      logic [31:0] instr, logic [31:0] ifpc, logic [1:0] psel, logic tr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = idr; v.redv = redv; v.sel = sel; v.tgt = tgt;
    v.reqv = reqv; v.addr = addr; v.ifv = ifv; v.instr = instr; v.ifpc = ifpc; v.psel = psel; v.tr = tr;
    return v;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic expect_out(string tag, vec_t v);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(v.reqv));
    chk({tag, " addr"}, imem_addr, v.addr);
    chk({tag, " if_valid"}, 32'(if_valid), 32'(v.ifv));
    chk({tag, " pc_sel"}, 32'(pc_sel), 32'(v.psel));
    chk({tag, " trap"}, 32'(trap), 32'(v.tr));
    if (v.ifv) begin
      chk({tag, " if_instr"}, if_instr, v.instr);
      chk({tag, " if_pc"}, if_pc, v.ifpc);
    end
  endtask
  task automatic step(string tag, vec_t v);
    imem_req_ready = v.rdy; imem_rsp_valid = v.rv; imem_rsp_data = v.rdata; id_ready = v.idr;
    redirect_valid = v.redv; redirect_sel = v.sel;
    pc_plus_imm = v.sel == 2'b01 ? v.tgt : v.tgt + 32'h40;
    alu_target  = v.sel == 2'b10 ? v.tgt : v.tgt + 32'h80;
    and_target  = v.sel == 2'b11 ? v.tgt : v.tgt + 32'hC0;
    @(posedge clk); #1;
    expect_out(tag, v);
  endtask
  initial begin
    vec_t idle;
    idle = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; id_ready = 1;
    redirect_valid = 0; redirect_sel = 0; pc_plus_imm = 0; alu_target = 0; and_target = 0;
    // sequential fetch 0x0, 0x4, then ready stall at 0x8
    vecs.push_back(mk(1,0,0,1,0,0,0,            1,32'h0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'h0,0,0,0,0,0));
    vecs.push_back(mk(1,1,32'hA0,1,0,0,0,       0,32'h4,1,32'hA0,32'h0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            1,32'h4,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'h4,0,0,0,0,0));
    vecs.push_back(mk(1,1,32'hA1,1,0,0,0,       0,32'h8,1,32'hA1,32'h4,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            1,32'h8,0,0,0,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'h8,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'h8,0,0,0,0,0));
    vecs.push_back(mk(1,1,32'h00500093,1,0,0,0, 0,32'hC,1,32'h00500093,32'h8,0,0));
    // decode stall holds the instruction
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'hC,1,32'h00500093,32'h8,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            1,32'hC,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'hC,0,0,0,0,0));
    // redirect in WAIT: response for 0xC dropped
    vecs.push_back(mk(1,0,0,1,1,2'b01,32'h100,  0,32'h100,0,0,0,1,0));
    vecs.push_back(mk(1,1,32'hA3,1,0,0,0,       1,32'h100,0,0,0,1,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'h100,0,0,0,1,0));
    vecs.push_back(mk(1,1,32'hA4,1,0,0,0,       0,32'h104,1,32'hA4,32'h100,0,0));
    // redirect in HOLD beats id_ready stall
    vecs.push_back(mk(1,0,0,0,1,2'b11,32'h200,  1,32'h200,0,0,0,3,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'h200,0,0,0,3,0));
    vecs.push_back(mk(1,1,32'hA5,1,0,0,0,       0,32'h204,1,32'hA5,32'h200,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            1,32'h204,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'h204,0,0,0,0,0));
    vecs.push_back(mk(1,1,32'hA6,1,0,0,0,       0,32'h208,1,32'hA6,32'h204,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            1,32'h208,0,0,0,0,0));
    // redirect in the accept cycle: old fetch becomes stale
    vecs.push_back(mk(1,0,0,1,1,2'b10,32'h300,  0,32'h300,0,0,0,2,0));
    vecs.push_back(mk(1,1,32'hA7,1,0,0,0,       1,32'h300,0,0,0,2,0));
    // abandoned unaccepted request, then sel=00 ignored
    vecs.push_back(mk(0,0,0,1,1,2'b01,32'h400,  1,32'h400,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,1,1,2'b00,32'h500,  1,32'h400,0,0,0,1,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'h400,0,0,0,1,0));
    // redirect coincident with response
    vecs.push_back(mk(1,1,32'hBAD,1,1,2'b10,32'h600, 1,32'h600,0,0,0,2,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'h600,0,0,0,2,0));
    vecs.push_back(mk(1,1,32'hA8,1,0,0,0,       0,32'h604,1,32'hA8,32'h600,0,0));
    // misaligned JALR target
    vecs.push_back(mk(1,0,0,1,1,2'b10,32'h102,  1,MA,0,0,0,MS,TR));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,MA,0,0,0,MS,0));
    vecs.push_back(mk(1,1,32'hA9,1,0,0,0,       0,MA+32'h4,1,32'hA9,MA,0,0));
    // PC wraps modulo 2^32
    vecs.push_back(mk(1,0,0,0,1,2'b01,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,0,0,0,1,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            0,32'hFFFF_FFFC,0,0,0,1,0));
    vecs.push_back(mk(1,1,32'hAA,1,0,0,0,       0,32'h0,1,32'hAA,32'hFFFF_FFFC,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,            1,32'h0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", idle);
    rst = 1'b0;
    foreach (vecs[i]) step($sformatf("row%0d", i), vecs[i]);
    // asynchronous reset while holding an instruction; late response ignored
    step("pre_rst0", mk(1,0,0,0,0,0,0, 0,32'h0,0,0,0,0,0));
    step("pre_rst1", mk(1,1,32'hBB,0,0,0,0, 0,32'h4,1,32'hBB,32'h0,0,0));
    imem_rsp_valid = 1'b0;
    #3 rst = 1'b1;
    #1 expect_out("async_rst", idle);
    imem_rsp_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst0", mk(0,1,32'hCC,1,0,0,0, 1,32'h0,0,0,0,0,0));
    step("post_rst1", mk(0,1,32'hCC,1,0,0,0, 1,32'h0,0,0,0,0,0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
